// File: rtl/l2_cache_wb.sv
// rtl/l2_cache_wb.sv - set-associative write-back L2 cache with per-line dirty bits and true-LRU replacement
module l2_cache_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 512,
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_WAYS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   l1_addr,
    input  logic [DATA_WIDTH-1:0]   l1_wdata,
    input  logic                    l1_read,
    input  logic                    l1_write,
    output logic                    l1_ready,
    output logic                    l1_hit,
    output logic                    l1_block_valid,
    output logic [BLOCK_SIZE*8-1:0] l1_block_data_out,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [BLOCK_SIZE*8-1:0] mem_block_out,
    input  logic [BLOCK_SIZE*8-1:0] mem_block_in,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic                    mem_ready
);

    localparam int WB    = DATA_WIDTH / 8;
    localparam int WPB   = BLOCK_SIZE / WB;
    localparam int SETS  = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF   = $clog2(BLOCK_SIZE);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = ADDR_WIDTH - IDX - OFF;
    localparam int BW    = BLOCK_SIZE * 8;
    localparam int WOFF  = $clog2(WB);
    localparam int WSEL  = $clog2(WPB);
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {IDLE, LOOKUP, EVICT, REFILL} state_t;

    state_t state, state_d;

    logic [BW-1:0]         data_mem  [SETS][NUM_WAYS];
    logic [TAG-1:0]        tag_mem   [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_mem [SETS];
    logic [NUM_WAYS-1:0]   dirty_mem [SETS];
    logic [WAY_W-1:0]      age_mem   [SETS][NUM_WAYS];

    logic [TAG-1:0]        req_tag;
    logic [IDX-1:0]        req_idx;
    logic [WSEL-1:0]       req_wsel;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_write;
    logic [WAY_W-1:0]      victim_way;

    logic                  hit, inv_found;
    logic [WAY_W-1:0]      hit_way, inv_way, lru_way, victim_c;
    logic                  victim_dirty;
    logic [BW-1:0]         hit_line, hit_merged, victim_line, refill_line;

    logic                  accept, victim_we, data_we, install;
    logic                  dirty_set, dirty_clr, touch;
    logic [WAY_W-1:0]      data_way, touch_way;
    logic [BW-1:0]         data_line;

    logic                  l1_ready_d, l1_hit_d, blk_valid_d, mem_read_d, mem_write_d;
    logic [BW-1:0]         blk_data_d, mem_block_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;

    logic                  unused_ok;
    assign unused_ok = &{1'b0, l1_addr[WOFF-1:0]};

    function automatic logic [BW-1:0] merge_word(input logic [BW-1:0] line,
                                                 input logic [WSEL-1:0] sel,
                                                 input logic [DATA_WIDTH-1:0] w);
        logic [BW-1:0] m;
        m = line;
        m[sel*DATA_WIDTH +: DATA_WIDTH] = w;
        return m;
    endfunction

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_mem[req_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
    end

    assign victim_c     = inv_found ? inv_way : lru_way;
    assign victim_dirty = valid_mem[req_idx][victim_c] && dirty_mem[req_idx][victim_c];
    assign hit_line     = data_mem[req_idx][hit_way];
    assign victim_line  = data_mem[req_idx][victim_c];
    assign hit_merged   = merge_word(hit_line, req_wsel, req_wdata);
    assign refill_line  = req_write ? merge_word(mem_block_in, req_wsel, req_wdata) : mem_block_in;

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        victim_we   = 1'b0;
        data_we     = 1'b0;
        data_way    = '0;
        data_line   = '0;
        install     = 1'b0;
        dirty_set   = 1'b0;
        dirty_clr   = 1'b0;
        touch       = 1'b0;
        touch_way   = '0;
        l1_ready_d  = 1'b0;
        l1_hit_d    = 1'b0;
        blk_valid_d = 1'b0;
        blk_data_d  = l1_block_data_out;
        mem_addr_d  = mem_addr;
        mem_block_d = mem_block_out;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        case (state)
            IDLE: begin
                // l1_ready still high means the L1 has not yet seen completion.
                if ((l1_read || l1_write) && !l1_ready) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    l1_ready_d = 1'b1;
                    l1_hit_d   = 1'b1;
                    touch      = 1'b1;
                    touch_way  = hit_way;
                    if (req_write) begin
                        data_we   = 1'b1;
                        data_way  = hit_way;
                        data_line = hit_merged;
                        dirty_set = 1'b1;
                    end else begin
                        blk_valid_d = 1'b1;
                        blk_data_d  = hit_line;
                    end
                    state_d = IDLE;
                end else begin
                    victim_we = 1'b1;
                    if (victim_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_mem[req_idx][victim_c], req_idx, {OFF{1'b0}}};
                        mem_block_d = victim_line;
                        state_d     = EVICT;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx, {OFF{1'b0}}};
                        state_d    = REFILL;
                    end
                end
            end
            EVICT: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    dirty_clr   = 1'b1;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {req_tag, req_idx, {OFF{1'b0}}};
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    data_we    = 1'b1;
                    data_way   = victim_way;
                    data_line  = refill_line;
                    install    = 1'b1;
                    touch      = 1'b1;
                    touch_way  = victim_way;
                    l1_ready_d = 1'b1;
                    if (!req_write) begin
                        blk_valid_d = 1'b1;
                        blk_data_d  = refill_line;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            l1_ready          <= 1'b0;
            l1_hit            <= 1'b0;
            l1_block_valid    <= 1'b0;
            l1_block_data_out <= '0;
            mem_addr          <= '0;
            mem_block_out     <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
        end else begin
            state             <= state_d;
            l1_ready          <= l1_ready_d;
            l1_hit            <= l1_hit_d;
            l1_block_valid    <= blk_valid_d;
            l1_block_data_out <= blk_data_d;
            mem_addr          <= mem_addr_d;
            mem_block_out     <= mem_block_d;
            mem_read          <= mem_read_d;
            mem_write         <= mem_write_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_tag    <= '0;
            req_idx    <= '0;
            req_wsel   <= '0;
            req_wdata  <= '0;
            req_write  <= 1'b0;
            victim_way <= '0;
        end else begin
            if (accept) begin
                req_tag   <= l1_addr[ADDR_WIDTH-1 -: TAG];
                req_idx   <= l1_addr[OFF +: IDX];
                req_wsel  <= l1_addr[WOFF +: WSEL];
                req_wdata <= l1_wdata;
                req_write <= l1_write;
            end
            if (victim_we) begin
                victim_way <= victim_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_mem[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (install) begin
                valid_mem[req_idx][victim_way] <= 1'b1;
                dirty_mem[req_idx][victim_way] <= req_write;
            end
            if (dirty_set) begin
                dirty_mem[req_idx][hit_way] <= 1'b1;
            end
            if (dirty_clr) begin
                dirty_mem[req_idx][victim_way] <= 1'b0;
            end
            // Younger ways age by one; the touched way becomes youngest.
            if (touch) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == touch_way) begin
                        age_mem[req_idx][w] <= '0;
                    end else if (age_mem[req_idx][w] < age_mem[req_idx][touch_way]) begin
                        age_mem[req_idx][w] <= age_mem[req_idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Line storage is qualified by VALID, so it needs no reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[req_idx][data_way] <= data_line;
        end
        if (install) begin
            tag_mem[req_idx][victim_way] <= req_tag;
        end
    end

endmodule
